lru_state_array: RTL and testbench

Per-set storage for pseudo-LRU replacement state in the cache datapath. The cache controller reads a set's PLRU bits on lookup, feeds them to the combinational replacement-policy logic, and writes the updated state back here. The block also clears all sets after reset or on a flush request. It is modelled as a synchronous-read array, so the per-set storage flops carry no reset.

---
 rtl/lru_state_array.sv | 86 ++++++++
 tb/tb_lru_state_array.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lru_state_array.sv
// Per-set pseudo-LRU state storage with a clear sweep after reset and on flush.
// Optional macro LRU_STATE_BYPASS_EN enables write-first forwarding on a same-set read/write.
module lru_state_array #(
   parameter int NUM_SETS = 16,
   parameter int STATE_W  = 1,
   localparam int SET_W   = $clog2(NUM_SETS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   output logic               init_busy_o,
   input  logic               rd_valid_i,
   output logic               rd_ready_o,
   input  logic [SET_W-1:0]   rd_set_i,
   output logic               rd_rvalid_o,
   output logic [STATE_W-1:0] rd_state_o,
   input  logic               wr_valid_i,
   input  logic [SET_W-1:0]   wr_set_i,
   input  logic [STATE_W-1:0] wr_state_i
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

   state_t             state;
   logic [SET_W-1:0]   sweep_cnt;
   logic [STATE_W-1:0] mem [NUM_SETS];
   logic               hazard;
   logic               rd_accept;
   logic [STATE_W-1:0] rd_data_next;

   assign hazard = wr_valid_i && rd_valid_i && (wr_set_i == rd_set_i);

`ifdef LRU_STATE_BYPASS_EN
   assign rd_ready_o   = (state == S_RUN) && !flush_i;
   assign rd_data_next = hazard ? wr_state_i : mem[rd_set_i];
`else
   // Without forwarding, a same-set hazard stalls the read one cycle so it sees the new value.
   assign rd_ready_o   = (state == S_RUN) && !flush_i && !hazard;
   assign rd_data_next = mem[rd_set_i];
`endif

   assign rd_accept = rd_valid_i && rd_ready_o;

   // Storage has no reset; the sweep clears it, and writes arriving with a flush are dropped.
   always_ff @(posedge clk_i) begin
      if (state == S_INIT) begin
         mem[sweep_cnt] <= '0;
      end else if (wr_valid_i && !flush_i) begin
         mem[wr_set_i] <= wr_state_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_INIT;
         sweep_cnt   <= '0;
         init_busy_o <= 1'b1;
         rd_rvalid_o <= 1'b0;
         rd_state_o  <= '0;
      end else begin
         rd_rvalid_o <= rd_accept;
         if (rd_accept) begin
            rd_state_o <= rd_data_next;
         end
         case (state)
            S_INIT: begin
               sweep_cnt <= sweep_cnt + 1'b1;
               if (sweep_cnt == LAST_SET) begin
                  state       <= S_RUN;
                  init_busy_o <= 1'b0;
               end
            end
            S_RUN: begin
               if (flush_i) begin
                  state       <= S_INIT;
                  sweep_cnt   <= '0;
                  init_busy_o <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lru_state_array.sv
// Directed bench for lru_state_array: a cycle model predicts ready/busy and queues expected read data.
module tb_lru_state_array;

   localparam int NUM_SETS = 16;
   localparam int STATE_W  = 1;
   localparam int SET_W    = $clog2(NUM_SETS);
`ifdef LRU_STATE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               flush_i = 1'b0;
   logic               init_busy_o;
   logic               rd_valid_i = 1'b0;
   logic               rd_ready_o;
   logic [SET_W-1:0]   rd_set_i = '0;
   logic               rd_rvalid_o;
   logic [STATE_W-1:0] rd_state_o;
   logic               wr_valid_i = 1'b0;
   logic [SET_W-1:0]   wr_set_i = '0;
   logic [STATE_W-1:0] wr_state_i = '0;

   int checks = 0;
   int failures = 0;

   bit                 m_run = 1'b0;
   int                 m_cnt = 0;
   logic [STATE_W-1:0] m_mem [NUM_SETS];
   logic [STATE_W-1:0] sb [$];

   lru_state_array #(.NUM_SETS(NUM_SETS), .STATE_W(STATE_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .init_busy_o(init_busy_o),
      .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_set_i(rd_set_i),
      .rd_rvalid_o(rd_rvalid_o), .rd_state_o(rd_state_o),
      .wr_valid_i(wr_valid_i), .wr_set_i(wr_set_i), .wr_state_i(wr_state_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check ready/busy before the edge, advance the model, check the read response after it.
   task automatic applyStimulus();
      bit hz, exp_ready, acc;
      @(negedge clk_i);
      hz        = wr_valid_i && rd_valid_i && (wr_set_i == rd_set_i);
      exp_ready = rst_ni && m_run && !flush_i && !(hz && !BYP);
      checkOutput("rd_ready", 32'(rd_ready_o), 32'(exp_ready));
      checkOutput("init_busy", 32'(init_busy_o), 32'(!m_run));
      acc = rd_valid_i && exp_ready;
      if (acc) sb.push_back((hz && BYP) ? wr_state_i : m_mem[rd_set_i]);
      if (rst_ni) begin
         if (!m_run) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == NUM_SETS - 1) m_run = 1'b1;
            m_cnt = (m_cnt + 1) % NUM_SETS;
         end else if (flush_i) begin
            m_run = 1'b0;
            m_cnt = 0;
         end else if (wr_valid_i) begin
            m_mem[wr_set_i] = wr_state_i;
         end
      end
      @(posedge clk_i);
      #1;
      if (acc) begin
         checkOutput("rd_rvalid", 32'(rd_rvalid_o), 32'd1);
         checkOutput("rd_state", 32'(rd_state_o), 32'(sb.pop_front()));
      end else begin
         checkOutput("rd_rvalid_idle", 32'(rd_rvalid_o), 32'd0);
      end
   endtask

   task automatic waitSweep();
      int n = 0;
      while (init_busy_o === 1'b1 && n < 40) begin
         applyStimulus();
         n++;
      end
      checkOutput("sweep_len", 32'(n), 32'(NUM_SETS));
   endtask

   task automatic enterReset();
      rst_ni = 1'b0;
      #1;
      m_run = 1'b0;
      m_cnt = 0;
      sb.delete();
      checkOutput("rst_busy", 32'(init_busy_o), 32'd1);
      checkOutput("rst_rvalid", 32'(rd_rvalid_o), 32'd0);
      checkOutput("rst_state", 32'(rd_state_o), 32'd0);
   endtask

   task automatic idle();
      rd_valid_i = 1'b0; wr_valid_i = 1'b0; flush_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NUM_SETS; i++) m_mem[i] = '0;
      $display("[TB] reset and initial sweep");
      @(posedge clk_i); #1;
      enterReset();
      applyStimulus();
      applyStimulus();
      rst_ni = 1'b1;
      waitSweep();

      for (int i = 0; i < NUM_SETS; i++) begin
         rd_valid_i = 1'b1; rd_set_i = SET_W'(i);
         applyStimulus();
      end
      idle();
      applyStimulus();

      $display("[TB] write then read");
      wr_valid_i = 1'b1; wr_set_i = 5; wr_state_i = 1;
      applyStimulus();
      wr_valid_i = 1'b0; rd_valid_i = 1'b1; rd_set_i = 5;
      applyStimulus();
      rd_set_i = 4;
      applyStimulus();
      idle();
      applyStimulus();

      $display("[TB] same-cycle hazard");
      wr_valid_i = 1'b1; wr_set_i = 3; wr_state_i = 1; rd_valid_i = 1'b1; rd_set_i = 3;
      applyStimulus();
      wr_valid_i = 1'b0;
      applyStimulus();
      idle();
      applyStimulus();

      $display("[TB] back-to-back reads");
      for (int i = 0; i < 3; i++) begin
         wr_valid_i = 1'b1; wr_set_i = SET_W'(i); wr_state_i = STATE_W'((i + 1) % 2);
         applyStimulus();
      end
      wr_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_valid_i = 1'b1; rd_set_i = SET_W'(i);
         applyStimulus();
      end
      idle();
      applyStimulus();

      $display("[TB] flush with dropped write and in-flight read");
      wr_valid_i = 1'b1; wr_set_i = 7; wr_state_i = 1;
      applyStimulus();
      wr_valid_i = 1'b0; rd_valid_i = 1'b1; rd_set_i = 7;
      applyStimulus();
      flush_i = 1'b1; wr_valid_i = 1'b1; wr_set_i = 2; wr_state_i = 1;
      applyStimulus();
      idle();
      waitSweep();
      rd_valid_i = 1'b1; rd_set_i = 2;
      applyStimulus();
      rd_set_i = 7;
      applyStimulus();
      idle();
      applyStimulus();

      $display("[TB] reset mid-sweep");
      flush_i = 1'b1;
      applyStimulus();
      idle();
      for (int i = 0; i < 7; i++) begin
         flush_i = (i == 3); wr_valid_i = (i == 3); wr_set_i = 9; wr_state_i = 1;
         applyStimulus();
      end
      idle();
      enterReset();
      applyStimulus();
      rst_ni = 1'b1;
      waitSweep();
      rd_valid_i = 1'b1; rd_set_i = 9;
      applyStimulus();
      idle();
      applyStimulus();

      $display("[TB] reset mid-read");
      wr_valid_i = 1'b1; wr_set_i = 11; wr_state_i = 1;
      applyStimulus();
      wr_valid_i = 1'b0; rd_valid_i = 1'b1; rd_set_i = 11;
      applyStimulus();
      idle();
      enterReset();
      applyStimulus();
      rst_ni = 1'b1;
      waitSweep();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
